key_debounce: RTL
=================

KEY_DEBOUNCE -- requirements
Module: key_debounce

Interface
REQ-001 Parameter CLK_FREQ, default 50_000_000, SHALL be the clk frequency in Hz.
REQ-002 Parameter DEBOUNCE_MS, default 20, SHALL be the required input stability time in ms.
REQ-003 Parameter N_KEYS, default 4, SHALL be the number of independent key channels.
REQ-004 clk  in  1  SHALL be the single system clock (50 MHz on board); all logic rising-edge.
REQ-005 rst  in  1  SHALL be a synchronous, active-high reset sampled on the rising edge of clk.
REQ-006 key_n  in  N_KEYS  SHALL be the raw board push-buttons: active-low, asynchronous, bouncing.
REQ-007 key_state  out  N_KEYS  SHALL give the debounced level per key, 1 = pressed.
REQ-008 key_press  out  N_KEYS  SHALL give a one-cycle pulse per key on each debounced press.
REQ-009 key_release  out  N_KEYS  SHALL give a one-cycle pulse per key on each debounced release.
REQ-010 press_cnt  out  8  SHALL give the running total of debounced presses across all keys.

Function
REQ-011 DB_CYCLES SHALL equal CLK_FREQ/1000*DEBOUNCE_MS (1_000_000 at defaults); the per-key counter SHALL be ceil(log2(DB_CYCLES)) bits wide.
REQ-012 Each key_n bit SHALL pass through a 2-flop synchronizer; the FSM SHALL use only the second-stage output (sync_n).
REQ-013 Per-key FSM states SHALL be IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT.
REQ-014 IDLE: sync_n=0 -> PRESS_WAIT, counter cleared to 0; otherwise remain in IDLE.
REQ-015 PRESS_WAIT: sync_n=1 -> IDLE (glitch rejected, no pulse); sync_n=0 and counter==DB_CYCLES-1 -> PRESSED; otherwise counter+1.
REQ-016 PRESSED: sync_n=1 -> RELEASE_WAIT, counter cleared to 0; otherwise remain in PRESSED.
REQ-017 RELEASE_WAIT: sync_n=0 -> PRESSED (no pulse); sync_n=1 and counter==DB_CYCLES-1 -> IDLE; otherwise counter+1.
REQ-018 key_press SHALL be registered and high for exactly the one cycle after the PRESS_WAIT->PRESSED edge; key_release SHALL behave the same on RELEASE_WAIT->IDLE.
REQ-019 key_state SHALL be 1 in PRESSED and RELEASE_WAIT and 0 otherwise, and SHALL change in the same cycle as the matching pulse.
REQ-020 Latency: if the first clk edge sampling a clean key_n low is edge 0, key_press SHALL be high in the cycle following edge DB_CYCLES+2; release timing SHALL be symmetric.
REQ-021 A bounce shorter than DB_CYCLES cycles SHALL produce no pulse and SHALL restart the count from 0 on the next qualifying edge.
REQ-022 Channels SHALL be fully independent; simultaneous presses SHALL each pulse in the same cycle.
REQ-023 press_cnt SHALL increment by popcount(key_press) each cycle and wrap modulo 256 (255 + 1 -> 0).

Reset
REQ-024 While rst=1: synchronizer flops SHALL be set to 1 (released), all FSMs SHALL be IDLE, all counters 0, and key_state, key_press, key_release and press_cnt SHALL be 0.
REQ-025 Reset asserted mid-debounce SHALL abort the count with no pulse; a key held through reset SHALL be reported as one fresh press per REQ-020, timed from the first edge after rst falls.

Structure
REQ-026 Package key_pkg SHALL hold the FSM state enum and a constant function that computes DB_CYCLES and the counter width.
REQ-027 Sub-module key_debounce_ch (synchronizer, FSM, counter and pulse registers for one key) SHALL be instantiated N_KEYS times; the top SHALL hold only press_cnt and the popcount.

Verification (CLK_FREQ=10_000, DEBOUNCE_MS=1, so DB_CYCLES=10)
REQ-028 Clean press on key 0, held 50 cycles -> key_press[0] high for 1 cycle after edge 12, key_state[0]=1, press_cnt=1.
REQ-029 Key 1 low for 6 cycles then high -> no key_press, key_state[1] stays 0, press_cnt unchanged.
REQ-030 Press key 2 with a 3-cycle bounce at start and at release -> exactly one key_press[2] pulse and one key_release[2] pulse, each 10 stable cycles after the last bounce plus sync delay.
REQ-031 Keys 0 and 3 pressed on the same edge -> both pulses in the same cycle, press_cnt +2; from press_cnt=255 a single press -> 0.
REQ-032 rst asserted at PRESS_WAIT count 5 with key held -> no pulse during reset; after rst falls, one key_press at edge 12 relative to the first post-reset edge.

Source files
------------

// File: rtl/key_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_pkg : debounce FSM state type and timing helper functions          |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package key_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } db_state_e;

  function automatic int calc_db_cycles(input int clk_freq, input int debounce_ms);
    return clk_freq / 1000 * debounce_ms;
  endfunction

  // ceil(log2(cycles)), never narrower than one bit
  function automatic int calc_cnt_width(input int cycles);
    int w;
    w = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < cycles) w = i + 1;
    end
    return w;
  endfunction

endpackage : key_pkg
`default_nettype wire

// File: rtl/key_debounce_ch.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_debounce_ch : one key channel - synchronizer, FSM, counter, pulses |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYCLES = 1_000_000,
  parameter int CNT_W     = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release
);

  localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(DB_CYCLES - 1);

  logic             r_meta_n;
  logic             r_sync_n;
  db_state_e        r_state;
  db_state_e        w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_press;
  logic             r_release;
  logic             w_press_nxt;
  logic             w_release_nxt;

  // Synchronizer idles high so a reset never looks like a press
  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta_n  <= 1'b1;
      r_sync_n  <= 1'b1;
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_meta_n  <= key_n;
      r_sync_n  <= r_meta_n;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_press   <= w_press_nxt;
      r_release <= w_release_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_press_nxt   = 1'b0;
    w_release_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (!r_sync_n) begin
          w_state_nxt = PRESS_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      PRESS_WAIT: begin
        if (r_sync_n) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt = PRESSED;
          w_press_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (r_sync_n) begin
          w_state_nxt = RELEASE_WAIT;
          w_cnt_nxt   = '0;
        end
      end
      RELEASE_WAIT: begin
        if (!r_sync_n) begin
          w_state_nxt = PRESSED;
        end else if (r_cnt == c_CNT_LAST) begin
          w_state_nxt   = IDLE;
          w_release_nxt = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + 1'b1;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  assign key_state   = (r_state == PRESSED) || (r_state == RELEASE_WAIT);
  assign key_press   = r_press;
  assign key_release = r_release;

endmodule : key_debounce_ch
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | key_debounce : N independent debounced keys plus a shared press count  |
// | Rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module key_debounce
  import key_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int N_KEYS      = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [7:0]        press_cnt
);

  localparam int c_DB_CYCLES = calc_db_cycles(CLK_FREQ, DEBOUNCE_MS);
  localparam int c_CNT_W     = calc_cnt_width(c_DB_CYCLES);

  logic [7:0] r_press_cnt;
  logic [7:0] w_pop;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_debounce_ch #(
      .DB_CYCLES (c_DB_CYCLES),
      .CNT_W     (c_CNT_W)
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .key_n       (key_n[i]),
      .key_state   (key_state[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i])
    );
  end

  always_comb begin
    w_pop = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      w_pop = w_pop + 8'(key_press[i]);
    end
  end

  // 8-bit accumulator wraps naturally modulo 256
  always_ff @(posedge clk) begin
    if (rst) begin
      r_press_cnt <= '0;
    end else begin
      r_press_cnt <= r_press_cnt + w_pop;
    end
  end

  assign press_cnt = r_press_cnt;

endmodule : key_debounce
`default_nettype wire
